// File: rtl/set_mode_controller.sv
// set_mode_controller: time-setting sequencer for the clock datapath.
// It steps RUN -> SET_HOUR -> SET_MIN -> RUN on Set releases. It returns to RUN
// after TIMEOUT_TICKS idle seconds in a set state. It turns Up presses into
// increment strobes.
// Optional feature macro: AUTOREPEAT_EN. When it is defined, holding Up makes
// the increment strobe repeat: first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles. When it is undefined, each Up rising edge gives exactly
// one strobe.
// Strobe semantics: every o_Counters_* strobe is a single-cycle, registered
// pulse. There is no handshake; downstream logic must act on it in that cycle.
// o_Mode is the FSM state register itself, so the state is directly observable.
module set_mode_controller #(
    parameter int TIMEOUT_TICKS = 30,
    parameter int REPEAT_DELAY  = 16384,
    parameter int REPEAT_PERIOD = 4096,
    parameter int CNT_W         = 15
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Enable_1Hz,
    input  logic       i_Set_Released,
    input  logic       i_Up_Level,
    output logic [1:0] o_Mode,
    output logic [2:0] o_Counters_Enable_Count,
    output logic       o_Counters_Enable_Increment,
    output logic       o_Counters_Reset,
    output logic [1:0] o_Display_Enable_Digits,
    output logic       o_Display_Enable_Dot
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_HOUR = 2'b01;
    localparam logic [1:0] ST_SET_MIN  = 2'b10;

    // Timeout fires on the tick that would bring the idle count to TIMEOUT_TICKS.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_TICKS - 1);

    logic [1:0] mode_d;
    logic [7:0] timeout_q, timeout_d;
    logic       up_q;
    logic       in_set, up_rise, up_fire, inc_event, timeout_hit;
    logic [2:0] count_d;
    logic [1:0] digits_d;
    logic       dot_d;

    assign in_set  = (o_Mode == ST_SET_HOUR) || (o_Mode == ST_SET_MIN);
    assign up_rise = i_Up_Level && !up_q;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    // Armed only after an Up edge accepted in a set state. A press held
    // across a mode change therefore never autorepeats.
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             armed_q, armed_d;
    logic             repeating_q, repeating_d;
    logic             repeat_fire;

    assign repeat_fire = armed_q && i_Up_Level &&
                         (hold_q == (repeating_q ? PERIOD_LAST : DELAY_LAST));

    // Hold/repeat counter: counts held cycles since the accepted edge and reloads on each repeat strobe.
    always_comb begin
        hold_d      = hold_q;
        armed_d     = armed_q;
        repeating_d = repeating_q;
        if (!in_set || !i_Up_Level || i_Set_Released || timeout_hit) begin
            hold_d      = '0;
            armed_d     = 1'b0;
            repeating_d = 1'b0;
        end else if (up_rise) begin
            hold_d      = '0;
            armed_d     = 1'b1;
            repeating_d = 1'b0;
        end else if (armed_q) begin
            if (repeat_fire) begin
                hold_d      = '0;
                repeating_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Hold/repeat registers.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            hold_q      <= '0;
            armed_q     <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            armed_q     <= armed_d;
            repeating_q <= repeating_d;
        end
    end

    assign up_fire = up_rise || repeat_fire;
`else
    assign up_fire = up_rise;
`endif

    // A Set release in the same cycle always wins over Up activity and over timeout.
    assign inc_event   = in_set && !i_Set_Released && up_fire;
    assign timeout_hit = in_set && !i_Set_Released && !inc_event &&
                         i_Enable_1Hz && (timeout_q == TO_LAST);

    // Next mode, idle-second count, and the per-mode outputs for the next mode.
    always_comb begin
        mode_d    = o_Mode;
        timeout_d = timeout_q;
        case (o_Mode)
            ST_RUN:      if (i_Set_Released) mode_d = ST_SET_HOUR;
            ST_SET_HOUR: begin
                if (i_Set_Released)   mode_d = ST_SET_MIN;
                else if (timeout_hit) mode_d = ST_RUN;
            end
            ST_SET_MIN:  if (i_Set_Released || timeout_hit) mode_d = ST_RUN;
            default:     mode_d = ST_RUN;
        endcase

        if (!in_set || i_Set_Released || inc_event || timeout_hit) begin
            timeout_d = '0;
        end else if (i_Enable_1Hz && (timeout_q != 8'hFF)) begin
            timeout_d = timeout_q + 8'd1;
        end

        count_d  = 3'b001;
        digits_d = 2'b00;
        dot_d    = 1'b1;
        case (mode_d)
            ST_SET_HOUR: begin
                count_d  = 3'b100;
                digits_d = 2'b01;
                dot_d    = 1'b0;
            end
            ST_SET_MIN: begin
                count_d  = 3'b010;
                digits_d = 2'b10;
                dot_d    = 1'b0;
            end
            default: ;
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            o_Mode                      <= ST_RUN;
            o_Counters_Enable_Count     <= 3'b001;
            o_Counters_Enable_Increment <= 1'b0;
            o_Counters_Reset            <= 1'b0;
            o_Display_Enable_Digits     <= 2'b00;
            o_Display_Enable_Dot        <= 1'b1;
            timeout_q                   <= '0;
            up_q                        <= 1'b0;
        end else begin
            o_Mode                      <= mode_d;
            o_Counters_Enable_Count     <= count_d;
            o_Counters_Enable_Increment <= inc_event;
            o_Counters_Reset            <= (o_Mode == ST_SET_MIN) && i_Set_Released;
            o_Display_Enable_Digits     <= digits_d;
            o_Display_Enable_Dot        <= dot_d;
            timeout_q                   <= timeout_d;
            up_q                        <= i_Up_Level;
        end
    end

endmodule

// File: doc/set_mode_controller.md
Name: set_mode_controller

Overview:
- Sequences time-setting for the clock datapath. It replaces the simple set-button stepping with a timed mode FSM.
- Drives the seconds/minutes/hours count enables, the increment strobe, the seconds reset and the blink masks for the display.
- Adds inactivity timeout back to run mode and hold-to-autorepeat on the Up button.
- Runs in the 32768 Hz i_Clock domain, between the button debouncers/clock_master and clock_counters/display.

Parameters:
- TIMEOUT_TICKS, 30, number of 1 Hz ticks without button activity in a set state before forced return to RUN (1..255).
- REPEAT_DELAY, 16384, i_Clock cycles Up must be held before the first autorepeat strobe (0.5 s).
- REPEAT_PERIOD, 4096, i_Clock cycles between subsequent autorepeat strobes (0.125 s).
- CNT_W, 15, width of the hold/repeat cycle counter; must satisfy 2^CNT_W > max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- i_Clock  in  1  system clock, 32768 Hz.
- i_Reset_n  in  1  synchronous active-low reset.
- i_Enable_1Hz  in  1  one-cycle pulse once per second.
- i_Set_Released  in  1  one-cycle pulse on Set button release (debounced).
- i_Up_Level  in  1  debounced Up button level, 1 = held.
- o_Mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
- o_Counters_Enable_Count  out  3  bit0 sec, bit1 min, bit2 hour count enable.
- o_Counters_Enable_Increment  out  1  one-cycle increment strobe to the selected counter.
- o_Counters_Reset  out  1  one-cycle seconds-reset strobe.
- o_Display_Enable_Digits  out  2  bit0 = blink hour digits, bit1 = blink minute digits.
- o_Display_Enable_Dot  out  1  1 = colon dot blinks.

Behaviour:
- One clock; reset is synchronous and active-low, sampled on posedge i_Clock.
- Reset values (any cycle, including mid-set or mid-repeat):
  - o_Mode = 00, Enable_Count = 001, Increment = 0, Reset = 0, Enable_Digits = 00, Dot = 1.
  - Timeout, hold and repeat counters = 0; Up edge register = 0.
- All outputs are registered. A state change is visible on outputs the cycle after the input pulse is sampled.
- FSM transitions:
  - RUN -> SET_HOUR on i_Set_Released.
  - SET_HOUR -> SET_MIN on i_Set_Released.
  - SET_MIN -> RUN on i_Set_Released. o_Counters_Reset pulses for exactly 1 cycle, coincident with the first RUN cycle.
  - Any SET state -> RUN when the timeout counter reaches TIMEOUT_TICKS. No o_Counters_Reset pulse.
- Per-state outputs:
  - RUN: Enable_Count = 001, Enable_Digits = 00, Dot = 1.
  - SET_HOUR: Enable_Count = 100, Enable_Digits = 01, Dot = 0.
  - SET_MIN: Enable_Count = 010, Enable_Digits = 10, Dot = 0.
- Up press handling, SET states only:
  - A rising edge of i_Up_Level produces one Increment pulse on the next cycle.
  - While held, the hold counter counts cycles. When it reaches REPEAT_DELAY, Increment pulses and the counter reloads.
  - After that, Increment pulses every REPEAT_PERIOD cycles.
  - Release clears the counter immediately. No pulse on release.
- Up in RUN: ignored, Increment stays 0, hold counter held at 0. A press held across RUN -> SET produces no pulse until a new rising edge.
- Timeout counter:
  - Counts i_Enable_1Hz pulses only in SET states.
  - Cleared on entering a SET state, on i_Set_Released, and on every Increment-generating event.
  - Activity clear wins over a simultaneous 1 Hz tick.
  - Saturates; no wrap.
- Simultaneous i_Set_Released and an Up event in the same cycle: the state transition wins and Increment is suppressed. The hold counter is cleared; a new edge is required.
- Timeout and i_Set_Released in the same cycle: i_Set_Released wins and follows the normal transition.
- Unused state encoding 11: next cycle goes to RUN with RUN outputs.

Optional Feature:
- Macro AUTOREPEAT_EN.
  - Defined: hold/autorepeat behaves as above.
  - Undefined: the hold/repeat counter logic is not compiled. Exactly one Increment per Up rising edge regardless of hold duration. REPEAT_DELAY, REPEAT_PERIOD and CNT_W are unused.

Test Plan:
- Bench parameters: TIMEOUT_TICKS=3, REPEAT_DELAY=8, REPEAT_PERIOD=4.
- Scenario 1, mode stepping: reset, then 3 Set pulses 10 cycles apart -> Mode 01, 10, 00. Enable_Count 100, 010, 001. o_Counters_Reset high exactly 1 cycle on return to 00. Dot = 0 only in SET states.
- Scenario 2, single press: in SET_HOUR raise Up for 3 cycles -> exactly 1 Increment pulse, 1 cycle after the rise. Up in RUN -> 0 pulses.
- Scenario 3, autorepeat (AUTOREPEAT_EN defined): in SET_MIN hold Up for 30 cycles -> pulses at offsets 1, 9, 13, 17, 21, 25, 29 from the rise. Release -> no further pulses. Without the macro -> 1 pulse only.
- Scenario 4, timeout: enter SET_HOUR, give 3 i_Enable_1Hz pulses with no buttons -> Mode 00 after the 3rd tick, o_Counters_Reset stays 0. An Up press between the 2nd and 3rd tick -> still in SET_HOUR after 3 ticks.
- Scenario 5, collisions: Set pulse and Up rise in the same cycle in SET_HOUR -> Mode 10, no Increment. Set pulse and 3rd tick in the same cycle -> Mode advances to 10, not 00.
- Scenario 6, reset mid-operation: i_Reset_n low for 1 cycle while holding Up in SET_MIN mid-repeat -> all outputs at reset values on the next cycle, and no Increment on the following 20 cycles while still held.
